// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, operand bundle type and index decode helper for operand_issue
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int NREG = 16;
  localparam int ADDR_W = 4;
  localparam int CTRL_W = 8;
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] rw;
    logic              wr;
    logic [CTRL_W-1:0] ctrl;
  } bundle_t;
  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-destination vector and RAW/WAW hazard query (OPERAND_ISSUE_WB_BYPASS_EN lets a same-cycle writeback release its hazard)
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_ra,
  input  logic [ADDR_W-1:0] i_rb,
  input  logic [ADDR_W-1:0] i_rw,
  input  logic              i_wr,
  input  logic              i_fire,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_rw,
  output logic              o_hazard
);
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_eff;
  // hazard query against the pending set, optionally with this cycle's writeback already retired
  always_comb begin
    w_clr = i_wb_valid ? onehot(i_wb_rw) : '0;
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    w_eff = r_pending & ~w_clr;
`else
    w_eff = r_pending;
`endif
    o_hazard = w_eff[i_ra] | w_eff[i_rb] | (i_wr & w_eff[i_rw]);
  end
  // retire writebacks, then mark the issuing destination so a same-index set wins over the clear
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_pending <= '0;
    else r_pending <= (r_pending & ~w_clr) | ((i_fire && i_wr) ? onehot(i_rw) : '0);
endmodule

// File: rtl/operand_issue.sv
// operand_issue: operand fetch/issue stage with scoreboard stalls and registered bundle (OPERAND_ISSUE_WB_BYPASS_EN forwards wb_data into operands)
module operand_issue
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_in_ra,
  input  logic [ADDR_W-1:0] i_in_rb,
  input  logic [ADDR_W-1:0] i_in_rw,
  input  logic              i_in_wr,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  output logic [ADDR_W-1:0] o_ra,
  output logic [ADDR_W-1:0] o_rb,
  input  logic [DATA_W-1:0] i_bus_a,
  input  logic [DATA_W-1:0] i_bus_b,
  output logic [ADDR_W-1:0] o_rw,
  output logic [DATA_W-1:0] o_bus_w,
  output logic              o_reg_wr,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_rw,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_a,
  output logic [DATA_W-1:0] o_out_b,
  output logic [ADDR_W-1:0] o_out_rw,
  output logic              o_out_wr,
  output logic [CTRL_W-1:0] o_out_ctrl
);
  logic    w_hazard;
  logic    w_fire;
  bundle_t w_next;
  bundle_t r_out;
  logic    r_out_valid;
  reg_scoreboard u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ra       (i_in_ra),
    .i_rb       (i_in_rb),
    .i_rw       (i_in_rw),
    .i_wr       (i_in_wr),
    .i_fire     (w_fire),
    .i_wb_valid (i_wb_valid),
    .i_wb_rw    (i_wb_rw),
    .o_hazard   (w_hazard)
  );
  // register file pass-through, handshake and next bundle assembly
  always_comb begin
    o_ra = i_in_ra;
    o_rb = i_in_rb;
    o_rw = i_wb_rw;
    o_bus_w = i_wb_data;
    o_reg_wr = i_wb_valid;
    o_in_ready = (!r_out_valid || i_out_ready) && !w_hazard;
    w_fire = i_in_valid && o_in_ready;
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    w_next.a = (i_wb_valid && i_wb_rw == i_in_ra) ? i_wb_data : i_bus_a;
    w_next.b = (i_wb_valid && i_wb_rw == i_in_rb) ? i_wb_data : i_bus_b;
`else
    w_next.a = i_bus_a;
    w_next.b = i_bus_b;
`endif
    w_next.rw = i_in_rw;
    w_next.wr = i_in_wr;
    w_next.ctrl = i_in_ctrl;
  end
  // output register loads on fire and empties when execute takes it without a replacement
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_out <= '0;
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out <= w_next;
      r_out_valid <= 1'b1;
    end else if (i_out_ready) r_out_valid <= 1'b0;
  assign o_out_valid = r_out_valid;
  assign o_out_a = r_out.a;
  assign o_out_b = r_out.b;
  assign o_out_rw = r_out.rw;
  assign o_out_wr = r_out.wr;
  assign o_out_ctrl = r_out.ctrl;
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: scoreboard bench with architectural register/in-flight model and randomized traffic
module tb_operand_issue;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, in_wr, wb_valid, out_ready, out_valid, out_wr, reg_wr;
  logic [ADDR_W-1:0] in_ra, in_rb, in_rw, ra_o, rb_o, rw_o, wb_rw, out_rw;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] bus_a, bus_b, bus_w, wb_data, out_a, out_b;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] arch [NREG];
  logic [NREG-1:0] infl = '0;
  bit mv = 1'b0;
  bit last_fire, last_rdy;
  bundle_t exp_q[$];
  logic [4:0] iq[$];
  logic [ADDR_W-1:0] wbq[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  operand_issue dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_ra(in_ra), .i_in_rb(in_rb), .i_in_rw(in_rw), .i_in_wr(in_wr), .i_in_ctrl(in_ctrl),
    .o_ra(ra_o), .o_rb(rb_o), .i_bus_a(bus_a), .i_bus_b(bus_b),
    .o_rw(rw_o), .o_bus_w(bus_w), .o_reg_wr(reg_wr),
    .i_wb_valid(wb_valid), .i_wb_rw(wb_rw), .i_wb_data(wb_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_a(out_a), .o_out_b(out_b),
    .o_out_rw(out_rw), .o_out_wr(out_wr), .o_out_ctrl(out_ctrl)
  );
  // external register file driven only through the DUT write port
  assign bus_a = regs[ra_o];
  assign bus_b = regs[rb_o];
  always @(posedge clk) if (reg_wr) regs[rw_o] <= bus_w;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    in_valid = 0; in_wr = 0; in_ra = 0; in_rb = 0; in_rw = 0; in_ctrl = 0;
    wb_valid = 0; wb_rw = 0; wb_data = 0; out_ready = 1;
  endtask
  task automatic wb(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    for (int i = 0; i < wbq.size(); i++) if (wbq[i] == r) begin wbq.delete(i); break; end
    wb_valid = 1; wb_rw = r; wb_data = d;
  endtask
  // one clock of the reference model: predict ready, record issued bundles, advance architectural state
  task automatic cyc();
    logic [NREG-1:0] eff;
    bit haz, slot, fire, acc;
    bundle_t e;
    logic [4:0] ent;
    #1;
    eff = infl;
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    if (wb_valid) eff[wb_rw] = 1'b0;
`endif
    haz = eff[in_ra] || eff[in_rb] || (in_wr && eff[in_rw]);
    slot = !mv || out_ready;
    last_rdy = in_ready;
    chk("in_ready", in_ready, slot && !haz);
    chk("ra_copy", ra_o, in_ra);
    chk("rb_copy", rb_o, in_rb);
    chk("regwr_copy", reg_wr, wb_valid);
    if (wb_valid) begin
      chk("rw_copy", rw_o, wb_rw);
      chk("busw_copy", bus_w, wb_data);
    end
    fire = in_valid && slot && !haz;
    acc = mv && out_ready;
    if (fire) begin
      e.a = arch[in_ra];
      e.b = arch[in_rb];
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
      if (wb_valid && wb_rw == in_ra) e.a = wb_data;
      if (wb_valid && wb_rw == in_rb) e.b = wb_data;
`endif
      e.rw = in_rw; e.wr = in_wr; e.ctrl = in_ctrl;
      exp_q.push_back(e);
    end
    last_fire = fire;
    @(posedge clk);
    if (wb_valid) begin arch[wb_rw] = wb_data; infl[wb_rw] = 1'b0; end
    if (acc) begin ent = iq.pop_front(); if (ent[4]) wbq.push_back(ent[3:0]); end
    if (fire) begin iq.push_back({in_wr, in_rw}); if (in_wr) infl[in_rw] = 1'b1; end
    mv = fire ? 1'b1 : (out_ready ? 1'b0 : mv);
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    #3 rst_n = 0;
    #1;
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_pending", dut.u_sb.r_pending, 0);
    exp_q.delete(); iq.delete(); wbq.delete(); infl = '0; mv = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  // monitor: compare the presented bundle with the oldest expected one, retire it on acceptance
  initial forever begin
    bundle_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("out_valid", out_valid, mv);
      if (out_valid) begin
        chk("bundle_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("out_a", out_a, e.a);
          chk("out_b", out_b, e.b);
          chk("out_rw", out_rw, e.rw);
          chk("out_wr", out_wr, e.wr);
          chk("out_ctrl", out_ctrl, e.ctrl);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_rw", out_rw, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_pending", dut.u_sb.r_pending, 0);
    wb_valid = 1; wb_rw = 9; wb_data = 32'hABCD;
    #1;
    chk("rst_wb_pass_en", reg_wr, 1);
    chk("rst_wb_pass_rw", rw_o, 9);
    chk("rst_wb_pass_data", bus_w, 32'hABCD);
    idle();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NREG; i++) begin
      wb_valid = 1; wb_rw = i[ADDR_W-1:0]; wb_data = (i == 3) ? 32'h1234_5678 : $urandom;
      cyc();
    end
    idle();
    in_valid = 1; in_ra = 3; in_rb = 3; in_ctrl = 8'h11;
    cyc();
    chk("t1_ready", last_rdy, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_a", out_a, 32'h1234_5678);
    chk("t1_b", out_b, 32'h1234_5678);
    chk("t1_pending", dut.u_sb.r_pending, 0);
    idle(); cyc();
    in_valid = 1; in_wr = 1; in_rw = 5; in_ctrl = 8'h22;
    cyc();
    in_wr = 0; in_ra = 5; in_rb = 1; in_ctrl = 8'h23;
    cyc(); chk("t2_stall0", last_rdy, 0);
    cyc(); chk("t2_stall1", last_rdy, 0);
    wb(5, 32'hDEAD_BEEF);
    cyc();
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    chk("t2_issue_on_wb", last_rdy, 1);
`else
    chk("t2_hold_on_wb", last_rdy, 0);
    wb_valid = 0;
    cyc();
    chk("t2_issue_after_wb", last_rdy, 1);
`endif
    chk("t2_a", out_a, 32'hDEAD_BEEF);
    idle(); cyc();
    in_valid = 1; in_wr = 1; in_rw = 7; in_ctrl = 8'h31;
    cyc();
    in_ctrl = 8'h32;
    cyc(); chk("t3_waw_stall", last_rdy, 0);
    wb(7, 32'h7777_0001);
    cyc();
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    chk("t3_issue_on_wb", last_rdy, 1);
`else
    chk("t3_hold_on_wb", last_rdy, 0);
    wb_valid = 0;
    cyc();
    chk("t3_issue_after_wb", last_rdy, 1);
`endif
    idle(); cyc();
    chk("t3_pending7", dut.u_sb.r_pending[7], 1);
    wb(7, 32'h7777_0002); cyc(); idle(); cyc();
    out_ready = 0; in_valid = 1; in_ra = 1; in_rb = 2; in_ctrl = 8'h40;
    cyc();
    in_ctrl = 8'h41;
    for (int k = 0; k < 4; k++) begin cyc(); chk("t4_backpressure", last_rdy, 0); end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin cyc(); chk("t4_stream", last_rdy, 1); in_ctrl = in_ctrl + 1; end
    idle(); cyc();
    in_valid = 1; in_wr = 1; in_rw = 5; cyc();
    in_rw = 7; cyc();
    idle(); out_ready = 0; cyc();
    chk("t5_pending_pre", dut.u_sb.r_pending, 16'h00A0);
    chk("t5_valid_pre", out_valid, 1);
    pulse_reset();
    in_valid = 1; in_ra = 5; in_rb = 7; out_ready = 1;
    cyc();
    chk("t5_no_stall", last_rdy, 1);
    idle(); cyc();
    for (int n = 0; n < 5000; n++) begin
      in_valid = ($urandom % 4) != 0;
      in_ra = ADDR_W'($urandom % 8);
      in_rb = ADDR_W'($urandom % NREG);
      in_rw = ADDR_W'($urandom % 8);
      in_wr = $urandom % 2;
      in_ctrl = CTRL_W'($urandom);
      out_ready = ($urandom % 4) != 0;
      wb_valid = 0;
      if (wbq.size() > 0 && ($urandom % 2) == 1) begin
        int k;
        k = $urandom % wbq.size();
        wb_valid = 1; wb_rw = wbq[k]; wb_data = $urandom;
        wbq.delete(k);
      end
      cyc();
    end
    idle();
    for (int k = 0; k < 20; k++) begin
      wb_valid = 0;
      if (wbq.size() > 0) begin wb_valid = 1; wb_rw = wbq.pop_front(); wb_data = $urandom; end
      cyc();
    end
    chk("drain_pending", dut.u_sb.r_pending, 0);
    chk("drain_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
